// File: rtl/exec_stage_seq_if.sv
// Handshake bundle between the E pipeline register, the execute stage and the memory stage.
// master = upstream/control side, slave = the execute stage itself.
interface exec_stage_seq_if #(
    parameter int unsigned DATA_W = 64
);
    logic [3:0]        E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [DATA_W-1:0] E_valC;
    logic [3:0]        E_dstE;
    logic [3:0]        E_dstM;
    logic [3:0]        m_stat;
    logic [3:0]        W_stat;
    logic              M_stall;
    logic              M_bubble;

    logic              e_busy;
    logic              e_cnd;
    logic [3:0]        M_stat;
    logic [3:0]        M_icode;
    logic              M_cnd;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic              ZF;
    logic              SF;
    logic              OF;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_stat, W_stat, M_stall, M_bubble,
        input  e_busy, e_cnd, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  ZF, SF, OF
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_stat, W_stat, M_stall, M_bubble,
        output e_busy, e_cnd, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output ZF, SF, OF
    );
endinterface

// File: rtl/exec_stage_seq.sv
// Clocked Y86-64 execute stage: ALU, condition codes, E->M pipeline register and an
// iterative shift-add mulq that stalls upstream while it runs.
module exec_stage_seq #(
    parameter int unsigned DATA_W = 64,
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned CNT_W  = 7
) (
    input logic             clk,
    input logic             reset,
    exec_stage_seq_if.slave bus
);
    localparam int unsigned MSB      = DATA_W - 1;
    localparam logic [3:0]  STAT_AOK = 4'h8;
    localparam logic [3:0]  STAT_INS = 4'h4;
    localparam logic [3:0]  RNONE    = 4'hF;
    localparam logic [3:0]  I_NOP    = 4'h1;
    localparam logic [3:0]  I_OPQ    = 4'h6;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_opq, is_mul, op_valid, mul_start, stats_ok, op_complete, cc_we;
    logic [DATA_W-1:0] alu_res, e_valE;
    logic              alu_of, e_cnd_w, e_busy_w;
    logic [3:0]        e_stat, e_dstE;

    // ---------------------------------------------------------------- decode
    assign is_opq    = (bus.E_icode == I_OPQ);
    assign is_mul    = is_opq && (bus.E_ifun == 4'h4) && MUL_EN;
    assign op_valid  = is_opq && ((bus.E_ifun < 4'h4) || is_mul);
    assign mul_start = is_mul && (bus.E_stat == STAT_AOK) && (state_q == StIdle);
    assign stats_ok  = (bus.E_stat == STAT_AOK) && (bus.m_stat == STAT_AOK) &&
                       (bus.W_stat == STAT_AOK);
    assign op_complete = !is_mul || (state_q == StDone);
    assign cc_we     = op_valid && stats_ok && !bus.M_stall && op_complete;

    assign e_stat = (is_opq && !op_valid) ? STAT_INS : bus.E_stat;

    // ---------------------------------------------------------------- multiply FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mul_start) state_d = StMul;
            StMul:  if (cnt_q == CNT_W'(1)) state_d = StDone;
            StDone: if (!bus.M_stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Busy is raised in the decode cycle itself so upstream freezes E immediately.
    always_comb begin
        e_busy_w = 1'b0;
        if (!reset) begin
            e_busy_w = (state_q == StMul) || mul_start;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (mul_start) begin
            mcand_q  <= bus.E_valA;
            mplier_q <= bus.E_valB;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(DATA_W);
        end else if (state_q == StMul) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------- ALU
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (bus.E_ifun)
            4'h0: begin
                alu_res = bus.E_valB + bus.E_valA;
                alu_of  = (bus.E_valA[MSB] == bus.E_valB[MSB]) &&
                          (alu_res[MSB] != bus.E_valB[MSB]);
            end
            4'h1: begin
                alu_res = bus.E_valB - bus.E_valA;
                alu_of  = (bus.E_valA[MSB] != bus.E_valB[MSB]) &&
                          (alu_res[MSB] != bus.E_valB[MSB]);
            end
            4'h2: alu_res = bus.E_valA & bus.E_valB;
            4'h3: alu_res = bus.E_valA ^ bus.E_valB;
            4'h4: alu_res = (state_q == StDone) ? acc_q : '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        e_valE = '0;
        case (bus.E_icode)
            4'h2:       e_valE = bus.E_valA;
            4'h3:       e_valE = bus.E_valC;
            4'h4, 4'h5: e_valE = bus.E_valB + bus.E_valC;
            4'h6:       e_valE = alu_res;
            4'h8, 4'hA: e_valE = bus.E_valB - DATA_W'(8);
            4'h9, 4'hB: e_valE = bus.E_valB + DATA_W'(8);
            default:    e_valE = '0;
        endcase
    end

    // ---------------------------------------------------------------- condition
    always_comb begin
        e_cnd_w = 1'b0;
        if (bus.E_icode == 4'h2 || bus.E_icode == 4'h7) begin
            case (bus.E_ifun)
                4'h0: e_cnd_w = 1'b1;
                4'h1: e_cnd_w = (bus.SF ^ bus.OF) | bus.ZF;
                4'h2: e_cnd_w = bus.SF ^ bus.OF;
                4'h3: e_cnd_w = bus.ZF;
                4'h4: e_cnd_w = ~bus.ZF;
                4'h5: e_cnd_w = ~(bus.SF ^ bus.OF);
                4'h6: e_cnd_w = ~((bus.SF ^ bus.OF) | bus.ZF);
                default: e_cnd_w = 1'b0;
            endcase
        end
    end

    // A not-taken cmov must not write its destination.
    assign e_dstE = (bus.E_icode == 4'h2 && !e_cnd_w) ? RNONE : bus.E_dstE;

    assign bus.e_busy = e_busy_w;
    assign bus.e_cnd  = e_cnd_w;

    // ---------------------------------------------------------------- CC register
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ZF <= 1'b1;
            bus.SF <= 1'b0;
            bus.OF <= 1'b0;
        end else if (cc_we) begin
            bus.ZF <= (alu_res == '0);
            bus.SF <= alu_res[MSB];
            bus.OF <= is_mul ? 1'b0 : alu_of;
        end
    end

    // ---------------------------------------------------------------- M register
    always_ff @(posedge clk) begin
        if (reset || (!bus.M_stall && (bus.M_bubble || e_busy_w))) begin
            bus.M_stat  <= STAT_AOK;
            bus.M_icode <= I_NOP;
            bus.M_cnd   <= 1'b0;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
        end else if (!bus.M_stall) begin
            bus.M_stat  <= e_stat;
            bus.M_icode <= bus.E_icode;
            bus.M_cnd   <= e_cnd_w;
            bus.M_valE  <= e_valE;
            bus.M_valA  <= bus.E_valA;
            bus.M_dstE  <= e_dstE;
            bus.M_dstM  <= bus.E_dstM;
        end
    end
endmodule

// File: doc/exec_stage_seq.md
Name: exec_stage_seq

Overview:
Parametrised, clocked successor to the combinational Y86-64 execute stage. It computes valE and Cnd from a condition-code register that updates on the clock. It also owns the E->M pipeline register and adds a multi-cycle iterative `mulq` (OPq ifun 4) that stalls upstream while running. It sits between the E pipeline register and the memory stage.

Parameters:
DATA_W, 64, datapath width in bits (valA/valB/valC/valE); min 8.
MUL_EN, 1, 1 = `mulq` supported; 0 = `mulq` decodes as invalid instruction.
CNT_W, 7, width of the multiply iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
E_stat  in  4  stage status (one-hot: 1=HLT, 2=ADR, 4=INS, 8=AOK)
E_icode  in  4  instruction code
E_ifun  in  4  function code
E_valA  in  DATA_W  operand A
E_valB  in  DATA_W  operand B
E_valC  in  DATA_W  constant
E_dstE  in  4  destination register for valE (15 = RNONE)
E_dstM  in  4  destination register for valM
m_stat  in  4  memory-stage status, used for CC gating
W_stat  in  4  writeback-stage status, used for CC gating
M_stall  in  1  hold the M register
M_bubble  in  1  load a bubble into the M register
e_busy  out  1  multiply in progress; upstream must stall F/D/E
e_cnd  out  1  combinational condition for the current E instruction
M_stat, M_icode  out  4 each  registered stat/icode
M_cnd  out  1  registered condition
M_valE, M_valA  out  DATA_W each  registered results
M_dstE, M_dstM  out  4 each  registered destinations
ZF, SF, OF  out  1 each  condition-code register

Behaviour:
- Reset:
  - ZF=1, SF=0, OF=0.
  - M register loads a bubble: M_stat=8, M_icode=1, M_cnd=0, M_valE=0, M_valA=0, M_dstE=15, M_dstM=15.
  - FSM returns to IDLE; e_busy=0.
  - Reset wins over every other input, including mid-multiply.
- valE by icode:
  - 2: valA.
  - 3: valC.
  - 4, 5: valB+valC.
  - 6: see OPq below.
  - 8, A: valB-8.
  - 9, B: valB+8.
  - 0, 1, 7: 0.
  - All arithmetic is modulo 2^DATA_W.
- OPq by ifun:
  - 0: valB+valA.
  - 1: valB-valA.
  - 2: valA&valB.
  - 3: valA^valB.
  - 4: low DATA_W bits of valA*valB (unsigned).
  - ifun>4, or ifun 4 with MUL_EN=0: e_stat forced to INS (4) and the CC register is not written.
- Flags for OPq:
  - ZF = (result==0).
  - SF = result[DATA_W-1].
  - OF = signed overflow for add/sub; 0 for and/xor/mul.
- CC write: occurs on a clock edge only when all of the following hold:
  - E_icode==6 with a valid ifun;
  - E_stat==8, m_stat==8 and W_stat==8;
  - M_stall==0;
  - the operation completes this cycle (single-cycle op, or FSM in DONE).
- e_cnd is evaluated from the current CC register:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~((SF^OF)|ZF).
  - e_cnd is 0 for icodes other than 2 and 7.
- cmovXX (icode 2) with e_cnd=0: M_dstE loads 15.
- M register update, in priority order:
  - reset → bubble.
  - M_stall → hold all values.
  - M_bubble → bubble.
  - e_busy → bubble.
  - otherwise load e_* values.
- Multiply FSM:
  - IDLE: on E_icode=6, ifun=4, MUL_EN=1, E_stat=8 → go to MUL. Load multiplicand=valA, multiplier=valB, acc=0, cnt=DATA_W. Drive e_busy=1 in this same cycle (combinational from decode).
  - MUL: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt--. e_busy=1. When cnt reaches 1, go to DONE.
  - DONE: e_busy=0. valE=acc. On the edge with M_stall==0, M loads the result, CC is written (if gated), and the FSM returns to IDLE. If M_stall==1, remain in DONE.
- Multiply latency:
  - e_busy is high for DATA_W+1 cycles (entry cycle plus DATA_W iterations).
  - The result enters M DATA_W+2 edges after `mulq` first appears in E.
  - Upstream holds E inputs stable while e_busy=1.
- m_stat/W_stat exceptions arising during a multiply: the multiply still completes and M loads the result, but CC is not written.

Test Plan:
- Reset for 2 cycles → M_icode=1, M_stat=8, M_dstE=15, M_dstM=15, ZF=1, SF=0, OF=0, e_busy=0.
- addq, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 → after the edge M_valE=0x8000_0000_0000_0000, OF=1, SF=1, ZF=0.
- subq 5,5 → ZF=1. Next cycle cmovle (ifun 1) dstE=3 → M_cnd=1, M_dstE=3. Then cmovg (ifun 6) → M_cnd=0, M_dstE=15.
- mulq valA=3, valB=7 → e_busy=1 for 65 cycles with M bubbles, then M_valE=21, ZF=0, OF=0. Repeat with valA=0 → ZF=1. Repeat with M_stall held 3 cycles at DONE → result held, then delivered.
- addq 1+1 with m_stat=2 → M_valE=2; CC remains at its previous values. Repeat with W_stat=1 → same.
- mulq with reset asserted at iteration 10 → next cycle e_busy=0, FSM IDLE, M bubble, CC at reset values.
- OPq with ifun=7 (and mulq with MUL_EN=0) → M_stat=4, CC unchanged, e_busy=0.
